// File: rtl/mem_rw_master_if.sv
// ============================================================================
//  Module      : mem_rw_master_if
//  Description : Bundle of the fetch/load-store client handshakes and the
//                single ram_rw memory port driven by mem_rw_master.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_rw_master_if;
  // Instruction fetch client
  logic        ifu_req_i;
  logic [63:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        ifu_err_o;

  // Load/store client
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [63:0] lsu_addr_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [63:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [63:0] lsu_rdata_o;
  logic        lsu_err_o;

  // Memory port
  logic        ram_rw_cen_o;
  logic        ram_rw_wen_o;
  logic [63:0] ram_rw_addr_o;
  logic [63:0] ram_rw_wdata_o;
  logic [7:0]  ram_rw_wmask_o;
  logic [2:0]  ram_rw_size_o;
  logic        ram_rw_ready_i;
  logic [63:0] ram_rw_data_i;

  // View of the memory master itself
  modport master (
    input  ifu_req_i, ifu_addr_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_size_i, lsu_unsigned_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    output ram_rw_wmask_o, ram_rw_size_o,
    input  ram_rw_ready_i, ram_rw_data_i
  );

  // View of the environment around it (clients and RAM responder)
  modport slave (
    output ifu_req_i, ifu_addr_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_size_i, lsu_unsigned_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    input  ram_rw_wmask_o, ram_rw_size_o,
    output ram_rw_ready_i, ram_rw_data_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_rw_master.sv
// ============================================================================
//  Module      : mem_rw_master
//  Description : Arbitrates instruction fetch and load/store requests onto one
//                64-bit ram_rw port, one request in flight. Formats store
//                lanes/masks and returns aligned fetch words and extended
//                load data. Optional WAIT timeout returns an error response.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_rw_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  mem_rw_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] timer;

  // Latched attributes of the request in flight
  logic       req_lsu;
  logic       req_we;
  logic [2:0] req_off;
  logic [1:0] req_size;
  logic       req_unsigned;

  // Grant decision: only in IDLE, load/store wins over fetch
  logic lsu_grant;
  logic ifu_grant;

  assign lsu_grant     = !reset && (state == IDLE) && bus.lsu_req_i;
  assign ifu_grant     = !reset && (state == IDLE) && bus.ifu_req_i && !bus.lsu_req_i;
  assign bus.lsu_gnt_o = lsu_grant;
  assign bus.ifu_gnt_o = ifu_grant;

  // Alignment of incoming requests: an access may not cross the 8-byte lane
  logic [2:0] lsu_off;
  logic [3:0] lsu_bytes;
  logic [3:0] lsu_end;
  logic       lsu_misaligned;
  logic       ifu_misaligned;

  assign lsu_off        = bus.lsu_addr_i[2:0];
  assign lsu_bytes      = 4'd1 << bus.lsu_size_i;
  assign lsu_end        = {1'b0, lsu_off} + lsu_bytes;
  assign lsu_misaligned = lsu_end > 4'd8;
  assign ifu_misaligned = |bus.ifu_addr_i[1:0];

  // Store lane placement; for a dword the 8-bit ones pattern wraps to 0xFF
  logic [7:0]  store_ones;
  logic [7:0]  store_wmask;
  logic [63:0] store_wdata;

  assign store_ones  = (8'd1 << lsu_bytes) - 8'd1;
  assign store_wmask = store_ones << lsu_off;
  assign store_wdata = bus.lsu_wdata_i << {lsu_off, 3'b000};

  // Read data formatting for the request in flight
  logic [63:0] load_shift;
  logic [63:0] load_data;
  logic [31:0] fetch_word;

  assign load_shift = bus.ram_rw_data_i >> {req_off, 3'b000};
  assign fetch_word = req_off[2] ? bus.ram_rw_data_i[63:32] : bus.ram_rw_data_i[31:0];

  // Keep the low bytes selected by size and extend them to 64 bits
  always_comb begin
    load_data = '0;
    case (req_size)
      2'd0: load_data = req_unsigned ? {56'd0, load_shift[7:0]}
                                     : {{56{load_shift[7]}}, load_shift[7:0]};
      2'd1: load_data = req_unsigned ? {48'd0, load_shift[15:0]}
                                     : {{48{load_shift[15]}}, load_shift[15:0]};
      2'd2: load_data = req_unsigned ? {32'd0, load_shift[31:0]}
                                     : {{32{load_shift[31]}}, load_shift[31:0]};
      default: load_data = load_shift;
    endcase
  end

  // Request FSM with registered memory strobes and client responses
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      timer              <= '0;
      req_lsu            <= 1'b0;
      req_we             <= 1'b0;
      req_off            <= 3'd0;
      req_size           <= 2'd0;
      req_unsigned       <= 1'b0;
      bus.ram_rw_cen_o   <= 1'b0;
      bus.ram_rw_wen_o   <= 1'b0;
      bus.ram_rw_addr_o  <= '0;
      bus.ram_rw_wdata_o <= '0;
      bus.ram_rw_wmask_o <= '0;
      bus.ram_rw_size_o  <= '0;
      bus.ifu_rvalid_o   <= 1'b0;
      bus.ifu_rdata_o    <= '0;
      bus.ifu_err_o      <= 1'b0;
      bus.lsu_rvalid_o   <= 1'b0;
      bus.lsu_rdata_o    <= '0;
      bus.lsu_err_o      <= 1'b0;
    end else begin
      // Strobes and response pulses last one cycle unless set below
      bus.ram_rw_cen_o   <= 1'b0;
      bus.ram_rw_wen_o   <= 1'b0;
      bus.ram_rw_addr_o  <= '0;
      bus.ram_rw_wdata_o <= '0;
      bus.ram_rw_wmask_o <= '0;
      bus.ram_rw_size_o  <= '0;
      bus.ifu_rvalid_o   <= 1'b0;
      bus.lsu_rvalid_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (lsu_grant) begin
            req_lsu      <= 1'b1;
            req_we       <= bus.lsu_we_i;
            req_off      <= lsu_off;
            req_size     <= bus.lsu_size_i;
            req_unsigned <= bus.lsu_unsigned_i;
            if (lsu_misaligned) begin
              // Rejected without touching memory
              bus.lsu_rvalid_o <= 1'b1;
              bus.lsu_err_o    <= 1'b1;
              bus.lsu_rdata_o  <= '0;
            end else begin
              state              <= ISSUE;
              bus.ram_rw_cen_o   <= 1'b1;
              bus.ram_rw_wen_o   <= bus.lsu_we_i;
              bus.ram_rw_addr_o  <= {bus.lsu_addr_i[63:3], 3'b000};
              bus.ram_rw_wdata_o <= bus.lsu_we_i ? store_wdata : 64'd0;
              bus.ram_rw_wmask_o <= bus.lsu_we_i ? store_wmask : 8'd0;
              bus.ram_rw_size_o  <= {1'b0, bus.lsu_size_i};
            end
          end else if (ifu_grant) begin
            req_lsu      <= 1'b0;
            req_we       <= 1'b0;
            req_off      <= bus.ifu_addr_i[2:0];
            req_size     <= 2'd2;
            req_unsigned <= 1'b0;
            if (ifu_misaligned) begin
              bus.ifu_rvalid_o <= 1'b1;
              bus.ifu_err_o    <= 1'b1;
              bus.ifu_rdata_o  <= '0;
            end else begin
              state             <= ISSUE;
              bus.ram_rw_cen_o  <= 1'b1;
              bus.ram_rw_addr_o <= {bus.ifu_addr_i[63:3], 3'b000};
              bus.ram_rw_size_o <= 3'd2;
            end
          end
        end

        ISSUE: begin
          state <= WAIT;
          timer <= '0;
        end

        WAIT: begin
          if (bus.ram_rw_ready_i) begin
            state <= IDLE;
            if (req_lsu) begin
              bus.lsu_rvalid_o <= 1'b1;
              bus.lsu_err_o    <= 1'b0;
              bus.lsu_rdata_o  <= req_we ? 64'd0 : load_data;
            end else begin
              bus.ifu_rvalid_o <= 1'b1;
              bus.ifu_err_o    <= 1'b0;
              bus.ifu_rdata_o  <= fetch_word;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            if (timer == TIMER_LAST) begin
              // Responder gave up on: report an error, late ready is ignored
              state <= IDLE;
              if (req_lsu) begin
                bus.lsu_rvalid_o <= 1'b1;
                bus.lsu_err_o    <= 1'b1;
                bus.lsu_rdata_o  <= '0;
              end else begin
                bus.ifu_rvalid_o <= 1'b1;
                bus.ifu_err_o    <= 1'b1;
                bus.ifu_rdata_o  <= '0;
              end
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_rw_master.sv
// ============================================================================
//  Module      : tb_mem_rw_master
//  Description : Directed plus randomized bench for mem_rw_master with a
//                byte-level reference model and a simple RAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_rw_master;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_rw_master_if bus ();

  mem_rw_master #(.TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Cycle index, read on the falling edge
  always @(posedge clock) cyc <= cyc + 1;

  // Responder controls
  bit          resp_never = 1'b0;
  int          resp_delay = 0;
  logic [63:0] resp_data  = '0;
  bit          pending    = 1'b0;
  int          wait_left  = 0;
  bit          stray      = 1'b0;

  // Memory-access log
  int          cen_cnt = 0;
  int          cen_cyc = -1;
  logic        cen_wen;
  logic [63:0] cen_addr;
  logic [63:0] cen_wdata;
  logic [7:0]  cen_wmask;
  logic [2:0]  cen_size;

  // Record each memory strobe and arm the responder
  always @(negedge clock) begin
    if (bus.ram_rw_cen_o === 1'b1) begin
      cen_cnt++;
      cen_cyc   = cyc;
      cen_wen   = bus.ram_rw_wen_o;
      cen_addr  = bus.ram_rw_addr_o;
      cen_wdata = bus.ram_rw_wdata_o;
      cen_wmask = bus.ram_rw_wmask_o;
      cen_size  = bus.ram_rw_size_o;
      if (!resp_never) begin
        pending   = 1'b1;
        wait_left = resp_delay;
      end
    end
  end

  // RAM responder: ready pulse after the configured delay, junk data otherwise
  initial begin
    bus.ram_rw_ready_i = 1'b0;
    bus.ram_rw_data_i  = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.ram_rw_ready_i = 1'b0;
      bus.ram_rw_data_i  = {$urandom, $urandom};
      if (stray) begin
        bus.ram_rw_ready_i = 1'b1;
        stray = 1'b0;
      end else if (pending) begin
        if (wait_left == 0) begin
          bus.ram_rw_ready_i = 1'b1;
          bus.ram_rw_data_i  = resp_data;
          pending = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: gather bytes starting at off, then extend
  function automatic logic [63:0] model_load(input logic [63:0] mem, input int off,
                                             input int size, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Reference: byte i of the bus carries byte (i - off) of the store data
  function automatic logic [63:0] model_store(input logic [63:0] wd, input int off);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) v[8*i +: 8] = wd[8*(i-off) +: 8];
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input int off, input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + n) m[i] = 1'b1;
    return m;
  endfunction

  // One complete transaction from request through response, fully checked
  task automatic run_txn(input bit is_lsu, input bit we, input logic [63:0] addr,
                         input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                         input logic [63:0] mem, input int delay, input string tag);
    int off, n, tg, tr, c0, exp_lat;
    bit mis, exp_err, got_lsu, got_ifu;
    logic [63:0] exp_rd, obs_rd;
    logic obs_err;
    off = int'(addr[2:0]);
    n   = is_lsu ? (1 << size) : 4;
    mis = is_lsu ? (off + n > 8) : (addr[1:0] != 2'b00);
    resp_data  = mem;
    resp_delay = delay;
    if (mis) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = '0;
    end else if (resp_never) begin
      exp_lat = 18; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = 3 + delay; exp_err = 1'b0;
      if (!is_lsu)  exp_rd = {32'd0, mem[32*addr[2] +: 32]};
      else if (we)  exp_rd = '0;
      else          exp_rd = model_load(mem, off, int'(size), uns);
    end

    @(posedge clock); #1;
    if (is_lsu) begin
      bus.lsu_req_i = 1'b1; bus.lsu_we_i = we; bus.lsu_addr_i = addr;
      bus.lsu_size_i = size; bus.lsu_unsigned_i = uns; bus.lsu_wdata_i = wdata;
    end else begin
      bus.ifu_req_i = 1'b1; bus.ifu_addr_i = addr;
    end
    @(negedge clock);
    tg = cyc;
    c0 = cen_cnt;
    chk({tag, "/gnt"},       is_lsu ? bus.lsu_gnt_o : bus.ifu_gnt_o, 64'd1);
    chk({tag, "/other_gnt"}, is_lsu ? bus.ifu_gnt_o : bus.lsu_gnt_o, 64'd0);
    @(posedge clock); #1;
    bus.lsu_req_i = 1'b0;
    bus.ifu_req_i = 1'b0;

    tr = -1; got_lsu = 0; got_ifu = 0; obs_rd = '0; obs_err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.lsu_rvalid_o || bus.ifu_rvalid_o) begin
        tr      = cyc;
        got_lsu = bus.lsu_rvalid_o;
        got_ifu = bus.ifu_rvalid_o;
        obs_rd  = is_lsu ? bus.lsu_rdata_o : {32'd0, bus.ifu_rdata_o};
        obs_err = is_lsu ? bus.lsu_err_o : bus.ifu_err_o;
        break;
      end
    end
    chk({tag, "/latency"},    64'(tr - tg), 64'(exp_lat));
    chk({tag, "/lsu_rvalid"}, 64'(got_lsu), 64'(is_lsu));
    chk({tag, "/ifu_rvalid"}, 64'(got_ifu), 64'(!is_lsu));
    chk({tag, "/err"},        64'(obs_err), 64'(exp_err));
    if (!(resp_never && !mis)) chk({tag, "/rdata"}, obs_rd, exp_rd);

    @(negedge clock);
    chk({tag, "/pulse"}, 64'(bus.lsu_rvalid_o | bus.ifu_rvalid_o), 64'd0);
    chk({tag, "/rdata_held"}, is_lsu ? bus.lsu_rdata_o : {32'd0, bus.ifu_rdata_o}, obs_rd);
    chk({tag, "/cen_count"}, 64'(cen_cnt - c0), mis ? 64'd0 : 64'd1);
    if (!mis) begin
      chk({tag, "/cen_cycle"}, 64'(cen_cyc - tg), 64'd1);
      chk({tag, "/addr"}, cen_addr, {addr[63:3], 3'b000});
      chk({tag, "/size"}, 64'(cen_size), is_lsu ? 64'(size) : 64'd2);
      chk({tag, "/wen"},  64'(cen_wen), 64'(is_lsu && we));
      if (is_lsu && we) begin
        chk({tag, "/wdata"}, cen_wdata, model_store(wdata, off));
        chk({tag, "/wmask"}, 64'(cen_wmask), 64'(model_mask(off, n)));
      end
      if (!is_lsu) chk({tag, "/wmask"}, 64'(cen_wmask), 64'd0);
    end
  endtask

  initial begin
    bit          r_lsu, r_we, r_uns, any_ev;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wd, r_mem;
    int          r_delay, tg, ig, lv, iv, c0;

    reset = 1'b1;
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 64'h8000_0000;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 64'h8000_0000;
    bus.lsu_size_i = 2'd0; bus.lsu_unsigned_i = 1'b0; bus.lsu_wdata_i = '0;

    // Reset state, including grants suppressed while requests are pending
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst/lsu_gnt",    64'(bus.lsu_gnt_o), 64'd0);
    chk("rst/ifu_gnt",    64'(bus.ifu_gnt_o), 64'd0);
    chk("rst/cen",        64'(bus.ram_rw_cen_o), 64'd0);
    chk("rst/addr",       bus.ram_rw_addr_o, 64'd0);
    chk("rst/lsu_rvalid", 64'(bus.lsu_rvalid_o), 64'd0);
    chk("rst/ifu_rvalid", 64'(bus.ifu_rvalid_o), 64'd0);
    chk("rst/lsu_rdata",  bus.lsu_rdata_o, 64'd0);
    chk("rst/ifu_err",    64'(bus.ifu_err_o), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.ifu_req_i = 1'b0;
    bus.lsu_req_i = 1'b0;

    // Directed accesses
    run_txn(0, 0, 64'h8000_0004, 2'd0, 0, 64'd0, 64'h00A00513_00000013, 0, "fetch");
    run_txn(1, 0, 64'h8000_0013, 2'd0, 0, 64'd0, 64'h11223344_80667788, 0, "lb");
    run_txn(1, 0, 64'h8000_0013, 2'd0, 1, 64'd0, 64'h11223344_80667788, 0, "lbu");
    run_txn(1, 0, 64'h8000_0018, 2'd3, 0, 64'd0, 64'hDEADBEEF_CAFEF00D, 0, "ld");
    run_txn(1, 1, 64'h8000_0006, 2'd1, 0, 64'h1234, 64'd0, 0, "sh");
    run_txn(1, 0, 64'h8000_0006, 2'd2, 0, 64'd0, 64'd0, 0, "lw_mis");
    run_txn(0, 0, 64'h8000_0002, 2'd0, 0, 64'd0, 64'd0, 0, "fetch_mis");

    // Simultaneous requests: load/store first, fetch granted with its response
    r_mem = 64'h0123_4567_89AB_CDEF;
    resp_data = r_mem; resp_delay = 0;
    @(posedge clock); #1;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 64'h8000_0040;
    bus.lsu_size_i = 2'd3; bus.lsu_unsigned_i = 1'b0;
    bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 64'h8000_0044;
    @(negedge clock);
    tg = cyc; c0 = cen_cnt;
    chk("arb/lsu_gnt", 64'(bus.lsu_gnt_o), 64'd1);
    chk("arb/ifu_gnt", 64'(bus.ifu_gnt_o), 64'd0);
    @(posedge clock); #1;
    bus.lsu_req_i = 1'b0;
    ig = -1; lv = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.lsu_rvalid_o) lv = cyc;
      if (bus.ifu_gnt_o) begin ig = cyc; break; end
    end
    chk("arb/lsu_latency", 64'(lv - tg), 64'd3);
    chk("arb/ifu_gnt_cycle", 64'(ig - tg), 64'd3);
    @(posedge clock); #1;
    bus.ifu_req_i = 1'b0;
    iv = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.ifu_rvalid_o) begin iv = cyc; break; end
    end
    chk("arb/ifu_latency", 64'(iv - ig), 64'd3);
    chk("arb/ifu_rdata", 64'(bus.ifu_rdata_o), 64'h0123_4567);
    @(negedge clock);
    chk("arb/cen_count", 64'(cen_cnt - c0), 64'd2);

    // Randomized traffic, mixed sizes, offsets and responder delays
    for (int it = 0; it < 40; it++) begin
      r_lsu   = ($urandom_range(0, 3) != 0);
      r_we    = $urandom_range(0, 1) != 0;
      r_uns   = $urandom_range(0, 1) != 0;
      r_size  = 2'($urandom_range(0, 3));
      r_wd    = {$urandom, $urandom};
      r_mem   = {$urandom, $urandom};
      r_delay = $urandom_range(0, 3);
      r_addr  = 64'h8000_0000 | 64'($urandom & 32'h0000_FFF8);
      if (r_lsu) r_addr[2:0] = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) r_addr[2:0] = 3'($urandom_range(0, 7));
      else r_addr[2] = 1'($urandom_range(0, 1));
      run_txn(r_lsu, r_we, r_addr, r_size, r_uns, r_wd, r_mem, r_delay, "rand");
    end

    // Responder silent: error after the timeout, late ready ignored
    resp_never = 1'b1;
    run_txn(1, 0, 64'h8000_0100, 2'd3, 0, 64'd0, 64'd0, 0, "timeout");
    run_txn(0, 0, 64'h8000_0200, 2'd0, 0, 64'd0, 64'd0, 0, "timeout_fetch");
    stray = 1'b1;
    any_ev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      any_ev |= bus.lsu_rvalid_o | bus.ifu_rvalid_o;
    end
    chk("timeout/late_ready", 64'(any_ev), 64'd0);
    resp_never = 1'b0;
    run_txn(1, 1, 64'h8000_0300, 2'd3, 0, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1, "after_timeout");

    // Reset while waiting on memory drops the request silently
    resp_never = 1'b1;
    @(posedge clock); #1;
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 64'h8000_0020;
    bus.lsu_size_i = 2'd3;
    @(negedge clock);
    chk("rstwait/gnt", 64'(bus.lsu_gnt_o), 64'd1);
    @(posedge clock); #1;
    bus.lsu_req_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstwait/cen",        64'(bus.ram_rw_cen_o), 64'd0);
    chk("rstwait/lsu_rvalid", 64'(bus.lsu_rvalid_o), 64'd0);
    chk("rstwait/lsu_err",    64'(bus.lsu_err_o), 64'd0);
    chk("rstwait/lsu_rdata",  bus.lsu_rdata_o, 64'd0);
    chk("rstwait/ifu_rdata",  64'(bus.ifu_rdata_o), 64'd0);
    resp_never = 1'b0;
    stray = 1'b1;
    any_ev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      any_ev |= bus.lsu_rvalid_o | bus.ifu_rvalid_o | bus.ram_rw_cen_o;
    end
    chk("rstwait/no_response", 64'(any_ev), 64'd0);
    run_txn(0, 0, 64'h8000_0400, 2'd0, 0, 64'd0, 64'hFEED_FACE_0BAD_F00D, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_rw_master.md
Name: mem_rw_master

Overview:
- Core-side initiator of the single ram_rw memory port, i.e. the requesting end of the interface served by the simulation top's RAM responder.
- Arbitrates instruction fetch (IFU) and load/store (LSU) requests onto that one port, with one request in flight at a time.
- Generates the 8-byte-lane address, write data, byte mask and size, and returns aligned instruction words and sign/zero-extended load data to the clients.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- ifu_req_i  in  1  fetch request; held until granted
- ifu_addr_i  in  64  fetch address
- ifu_gnt_o  out  1  fetch request accepted this cycle (combinational)
- ifu_rvalid_o  out  1  fetch response pulse
- ifu_rdata_o  out  32  instruction word
- ifu_err_o  out  1  fetch error; valid with ifu_rvalid_o
- lsu_req_i  in  1  load/store request; held until granted
- lsu_we_i  in  1  1 = store
- lsu_addr_i  in  64  byte address
- lsu_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- lsu_unsigned_i  in  1  zero-extend the load
- lsu_wdata_i  in  64  store data, right-aligned
- lsu_gnt_o  out  1  load/store request accepted (combinational)
- lsu_rvalid_o  out  1  load/store completion pulse
- lsu_rdata_o  out  64  extended load data; 0 for stores
- lsu_err_o  out  1  misaligned access or timeout
- ram_rw_cen_o  out  1  memory access strobe
- ram_rw_wen_o  out  1  write enable
- ram_rw_addr_o  out  64  {addr[63:3], 3'b0}
- ram_rw_wdata_o  out  64  lane-shifted store data
- ram_rw_wmask_o  out  8  byte mask
- ram_rw_size_o  out  3  {1'b0, size}; fetch drives 2
- ram_rw_ready_i  in  1  responder ready; read data valid when high
- ram_rw_data_i  in  64  read data

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, timeout counter clears. Reset mid-operation drops the in-flight request with no response, and cen is 0 in the following cycle.
- FSM states are IDLE, ISSUE and WAIT.
- Arbitration in IDLE:
  - LSU has priority over IFU. The loser's gnt is 0 and it keeps its request asserted.
  - Grant is only possible in IDLE. The granted request is latched (we, addr, size, unsigned, wdata, source).
- Misalignment check at grant:
  - LSU: addr[2:0] + (1 << size) > 8. IFU: addr[1:0] != 0.
  - A misaligned request stays in IDLE and drives no cen.
  - In the next cycle it pulses rvalid=1 and err=1 for the source; rdata is 0 and no memory access occurs.
- Aligned request timing, with grant at cycle T:
  - T+1, ISSUE: cen=1 for exactly one cycle; wen, addr, wdata, wmask and size are driven from the latched request. Next state is WAIT.
  - WAIT: ready_i is sampled only in this state; outside WAIT, ready_i and data_i are ignored. When ready_i=1, data_i is captured and the FSM returns to IDLE.
  - Nominal responder: ready arrives at T+2 and rvalid pulses at T+3 (registered).
  - A new grant is allowed in the same cycle as the rvalid pulse.
  - Non-ISSUE cycles drive all ram_rw_* outputs to 0.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter counts cycles in WAIT.
  - If it reaches TIMEOUT_CYCLES without ready: rvalid=1 and err=1 in the next cycle, FSM to IDLE.
  - A ready arriving after the timeout is ignored.
- Store lane formatting, with off = addr[2:0]:
  - wdata_o = wdata_i << (8*off).
  - wmask = ((1 << (1 << size)) - 1) << off, truncated to 8 bits.
- Load extraction:
  - Shift data_i right by 8*off, keep the low 8/16/32/64 bits by size.
  - Sign-extend from the top kept bit unless unsigned=1; size 3 ignores unsigned.
- Fetch extraction: rdata = addr[2] ? data_i[63:32] : data_i[31:0]. Fetch is always a read with wmask 0.
- Store completion: rvalid pulses with rdata=0 and err=0.
- rvalid is asserted only toward the source of the completed request, as a single-cycle pulse. rdata and err are held stable until the next response.

Test Plan:
- IFU fetch 0x80000004, responder returns data_i=0x00A00513_00000013 one cycle after cen -> gnt at T, cen=1 only at T+1 with addr 0x80000000 and size 2, ifu_rvalid at T+3, rdata=0x00A00513, err=0.
- LSU lb 0x80000013 with data_i byte3=0x80 -> lsu_rdata=0xFFFFFFFFFFFFFF80; same access with unsigned=1 -> 0x80; ld 0x80000018 -> rdata equals full data_i.
- LSU sh 0x80000006 with wdata=0x1234 -> cen=1, wen=1, wdata_o=0x1234000000000000, wmask=0xC0, size=1; lsu_rvalid with rdata=0.
- LSU lw 0x80000006 (misaligned) -> no cen ever; lsu_rvalid=1 and lsu_err=1 at T+1. IFU fetch at 0x80000002 -> ifu_err likewise.
- IFU and LSU requesting in the same IDLE cycle -> lsu_gnt=1, ifu_gnt=0; IFU is granted in the cycle LSU rvalid pulses; exactly two cen pulses in total.
- Responder never asserts ready with TIMEOUT_CYCLES=16 -> err+rvalid 17 cycles after cen, then IDLE. Reset asserted in WAIT -> all outputs 0 and no rvalid afterward.
